// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage feeding the fetch-side inputs of the IF/ID pipeline
// register. It owns the program counter and talks to a variable-latency
// instruction memory over a request/ready handshake. It also honours stall
// requests from the hazard unit and redirect requests from the execute stage.
//
// Ports
//   clk         in   1   single clock, all state updates on the rising edge
//   reset       in   1   asynchronous, active-high; clears all state at once
//   StallF      in   1   hazard-unit hold request; the PC must not advance
//   PCSrcE      in   1   taken branch/jump redirect from the execute stage
//   PCTargetE   in  32   redirect target; bits [1:0] are forced to 00
//   ImemReq     out  1   instruction memory request, held until ImemReady
//   ImemAddr    out 32   request address, stable while ImemReq is high
//   ImemReady   in   1   response valid this cycle (zero-wait allowed)
//   ImemRdata   in  32   instruction word, valid when ImemReady is high
//   InstrF      out 32   fetched instruction presented to IF/ID
//   PCF         out 32   PC of InstrF
//   PCPlus4F    out 32   PCF + 4, modulo 2^32
//   FetchStall  out  1   no valid instruction on InstrF this cycle
//
// States
//   S_FETCH  request outstanding at the PC; a response completes it
//   S_HOLD   word captured while stalled; memory idle, word replayed from buf
//   S_DRAIN  redirect arrived before the response; the in-flight request must
//            finish at its original address before the new PC is requested
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemRdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        FetchStall
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] buf_q,   buf_d;
  logic [31:0] redir_q, redir_d;

  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;

  // Redirect targets are word aligned; masking keeps every input bit in use.
  assign target_s   = PCTargetE & 32'hFFFF_FFFC;
  assign pc_plus4_s = pc_q + 32'd4;

  // PC-derived outputs come straight from the PC register.
  assign PCF      = pc_q;
  assign PCPlus4F = pc_plus4_s;
  assign ImemAddr = pc_q;

  // Next-state logic for the FSM and the PC / buffer / redirect registers.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    redir_d = redir_q;
    case (state_q)
      S_FETCH: begin
        if (PCSrcE && ImemReady) begin
          // Word belongs to the wrong path; the hazard unit flushes ID.
          pc_d = target_s;
        end else if (PCSrcE) begin
          // Cannot move the address mid-request: remember where to go.
          redir_d = target_s;
          state_d = S_DRAIN;
        end else if (ImemReady && !StallF) begin
          pc_d = pc_plus4_s;
        end else if (ImemReady) begin
          // Response arrived while stalled: park it so memory can go idle.
          buf_d   = ImemRdata;
          state_d = S_HOLD;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          // A redirect overrides the stall.
          pc_d    = target_s;
          state_d = S_FETCH;
        end else if (!StallF) begin
          pc_d    = pc_plus4_s;
          state_d = S_FETCH;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (ImemReady) begin
          // A redirect in the completing cycle is newer than the saved one.
          pc_d    = PCSrcE ? target_s : redir_q;
          state_d = S_FETCH;
        end else if (PCSrcE) begin
          redir_d = target_s;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      buf_q   <= NOP;
      redir_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      redir_q <= redir_d;
    end
  end

  // Handshake and instruction outputs. Reset forces the idle values so a
  // pending request is dropped the moment reset rises.
  always_comb begin
    ImemReq    = 1'b0;
    InstrF     = NOP;
    FetchStall = 1'b1;
    if (reset) begin
      ImemReq    = 1'b0;
      InstrF     = NOP;
      FetchStall = 1'b1;
    end else begin
      case (state_q)
        S_FETCH: begin
          ImemReq    = 1'b1;
          InstrF     = ImemReady ? ImemRdata : NOP;
          FetchStall = ~ImemReady;
        end
        S_HOLD: begin
          ImemReq    = 1'b0;
          InstrF     = buf_q;
          FetchStall = 1'b0;
        end
        S_DRAIN: begin
          ImemReq    = 1'b1;
          InstrF     = NOP;
          FetchStall = 1'b1;
        end
        default: begin
          ImemReq    = 1'b0;
          InstrF     = NOP;
          FetchStall = 1'b1;
        end
      endcase
    end
  end

endmodule
